// File: rtl/layer_generator_rand.sv
// Random platform-layer generator. Emits an initial map of INIT_LAYERS layers
// after generate_map_i, then one extra layer per next_layer_i request. Layers
// come from a seedable Galois LFSR and are patched so that every layer has at
// least one block adjacent to a block of the previous layer.
//
// state   | meaning
// --------+--------------------------------------------------------------
// S_IDLE  | waiting for generate_map_i; seed_load_i reloads the LFSR
// S_FIRST | registers the fixed single-block first layer
// S_GEN   | steps the LFSR and registers a reachable random layer
// S_WAIT  | layer presented on load_layer_o until layer_ack_i
// S_READY | initial map accepted; waits for next_layer_i / generate_map_i
module layer_generator_rand #(
    parameter int                LAYER_W     = 7,
    parameter int                INIT_LAYERS = 4,
    parameter int                LFSR_W      = 16,
    parameter logic [LFSR_W-1:0] LFSR_TAPS   = 16'hB400,
    parameter logic [LFSR_W-1:0] SEED        = 16'hACE1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               generate_map_i,
    input  logic               next_layer_i,
    input  logic               seed_load_i,
    input  logic [LFSR_W-1:0]  seed_in_i,
    input  logic               layer_ack_i,
    output logic [0:LAYER_W-1] layer_map_o,
    output logic [0:LAYER_W-1] block_type_o,
    output logic               load_layer_o,
    output logic               map_ready_o,
    output logic               busy_o,
    output logic [15:0]        layer_cnt_o
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FIRST = 3'd1,
        S_GEN   = 3'd2,
        S_WAIT  = 3'd3,
        S_READY = 3'd4
    } state_e;

    localparam logic [15:0] INIT_CNT = 16'(INIT_LAYERS);

    state_e             state_q, state_d;
    logic [LFSR_W-1:0]  lfsr_q, lfsr_d;
    logic [0:LAYER_W-1] map_q, map_d;
    logic [0:LAYER_W-1] type_q, type_d;
    logic               load_q, load_d;
    logic               ready_q, ready_d;
    logic [15:0]        cnt_q, cnt_d;

    logic [LFSR_W-1:0]  lfsr_next;
    logic [0:LAYER_W-1] cand, typ, reach, cand_fix, first_map;
    int                 p_idx, f_idx;

    function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] l);
        return {1'b0, l[LFSR_W-1:1]} ^ (l[0] ? LFSR_TAPS : '0);
    endfunction

    // Candidate layer from the next LFSR value, patched to stay reachable.
    always_comb begin
        lfsr_next = lfsr_step(lfsr_q);
        cand      = '0;
        typ       = '0;
        p_idx     = 0;
        for (int i = 0; i < LAYER_W; i++) begin
            cand[i] = lfsr_next[i];
            typ[i]  = lfsr_next[LAYER_W+i];
        end
        // Neighbourhood is symmetric, so shift direction does not matter.
        reach = map_q | (map_q << 1) | (map_q >> 1);
        for (int i = LAYER_W - 1; i >= 0; i--) begin
            if (map_q[i]) p_idx = i;
        end
        f_idx    = (p_idx + 1 == LAYER_W) ? p_idx - 1 : p_idx + 1;
        cand_fix = cand;
        if ((cand & reach) == '0) begin
            for (int i = 0; i < LAYER_W; i++) begin
                if (i == f_idx) cand_fix[i] = 1'b1;
            end
        end
        first_map              = '0;
        first_map[LAYER_W / 2] = 1'b1;
    end

    // Next-state and register-next logic of the sequencer.
    always_comb begin
        state_d = state_q;
        lfsr_d  = lfsr_q;
        map_d   = map_q;
        type_d  = type_q;
        load_d  = load_q;
        ready_d = ready_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (seed_load_i) lfsr_d = (seed_in_i != '0) ? seed_in_i : SEED;
                if (generate_map_i) begin
                    state_d = S_FIRST;
                    cnt_d   = '0;
                    ready_d = 1'b0;
                end
            end
            S_FIRST: begin
                map_d   = first_map;
                type_d  = '0;
                load_d  = 1'b1;
                state_d = S_WAIT;
            end
            S_GEN: begin
                lfsr_d  = lfsr_next;
                map_d   = cand_fix;
                type_d  = typ & cand_fix;
                load_d  = 1'b1;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (layer_ack_i) begin
                    load_d = 1'b0;
                    cnt_d  = cnt_q + 16'd1;
                    if ((cnt_d < INIT_CNT) && !ready_q) begin
                        state_d = S_GEN;
                    end else begin
                        ready_d = 1'b1;
                        state_d = S_READY;
                    end
                end
            end
            S_READY: begin
                if (generate_map_i) begin
                    state_d = S_FIRST;
                    ready_d = 1'b0;
                    cnt_d   = '0;
                end else if (next_layer_i) begin
                    state_d = S_GEN;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            lfsr_q  <= SEED;
            map_q   <= '0;
            type_q  <= '0;
            load_q  <= 1'b0;
            ready_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            lfsr_q  <= lfsr_d;
            map_q   <= map_d;
            type_q  <= type_d;
            load_q  <= load_d;
            ready_q <= ready_d;
            cnt_q   <= cnt_d;
        end
    end

    assign layer_map_o  = map_q;
    assign block_type_o = type_q;
    assign load_layer_o = load_q;
    assign map_ready_o  = ready_q;
    assign layer_cnt_o  = cnt_q;
    assign busy_o       = (state_q == S_FIRST) || (state_q == S_GEN) || (state_q == S_WAIT);

endmodule
